// File: rtl/thc_pkg.sv
// rtl/thc_pkg.sv - shared constants and codeword layout helpers for the Hamming decoder
package thc_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CW_W   = DATA_W + PAR_W;

  // Hamming positions (1-based) that hold parity bits.
  localparam int PAR_POS [PAR_W] = '{1, 2, 4, 8, 16, 32};

  function automatic bit is_par_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < PAR_W; k++) begin
      if (p == PAR_POS[k]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Data bit idx occupies the idx-th non-parity position, counting upward from 1.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p <= CW_W; p++) begin
      if (!is_par_pos(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Mask of all codeword bits whose Hamming position has bit k set.
  function automatic logic [CW_W-1:0] syn_mask(input int k);
    logic [CW_W-1:0] m;
    m = '0;
    for (int p = 1; p <= CW_W; p++) begin
      if (((p >> k) & 1) != 0) m = m | ({{(CW_W-1){1'b0}}, 1'b1} << (p - 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/thc_syndrome_calc.sv
// rtl/thc_syndrome_calc.sv - combinational even-parity syndrome of a 38-bit codeword
module thc_syndrome_calc
  import thc_pkg::*;
(
  input  logic [CW_W-1:0]  data_in,
  output logic [PAR_W-1:0] syndrome
);

  // Each syndrome bit is the parity over every position whose index has that bit set.
  for (genvar k = 0; k < PAR_W; k++) begin : g_syn
    localparam logic [CW_W-1:0] MASK = syn_mask(k);
    assign syndrome[k] = ^(data_in & MASK);
  end

endmodule

// File: rtl/thc_decoder.sv
// rtl/thc_decoder.sv - single-error-correcting Hamming decoder with one registered stage
module thc_decoder
  import thc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CW_W-1:0]   data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] org_data,
  output logic              error,
  output logic              uncorrectable,
  output logic [PAR_W-1:0]  syndrome
);

  localparam logic [CW_W-1:0]  ONE     = {{(CW_W-1){1'b0}}, 1'b1};
  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CW_W);

  logic [PAR_W-1:0]  syn;
  logic [CW_W-1:0]   flip;
  logic [CW_W-1:0]   corr;
  logic [DATA_W-1:0] data_ext;
  logic              err_d;
  logic              unc_d;

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              unc_q;
  logic [PAR_W-1:0]  syn_q;

  thc_syndrome_calc u_syn (
    .data_in  (data_in),
    .syndrome (syn)
  );

  // A syndrome in 1..38 names the flipped position; beyond that nothing is corrected.
  always_comb begin
    flip  = '0;
    err_d = (syn != '0);
    unc_d = (syn > MAX_POS);
    if (err_d && !unc_d) flip = ONE << (syn - PAR_W'(1));
  end

  assign corr = data_in ^ flip;

  // Pull data bits out of the non-parity positions in ascending order.
  for (genvar i = 0; i < DATA_W; i++) begin : g_ext
    localparam logic [CW_W-1:0] SEL = ONE << (data_pos(i) - 1);
    assign data_ext[i] = |(corr & SEL);
  end

  // Capture a decoded word when valid; otherwise hold results and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      unc_q   <= 1'b0;
      syn_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= data_ext;
        err_q  <= err_d;
        unc_q  <= unc_d;
        syn_q  <= syn;
      end
    end
  end

  assign out_valid     = valid_q;
  assign org_data      = data_q;
  assign error         = err_q;
  assign uncorrectable = unc_q;
  assign syndrome      = syn_q;

endmodule

// File: tb/tb_thc_decoder.sv
// tb/tb_thc_decoder.sv - self-checking bench for thc_decoder
module tb_thc_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [37:0] data_in;
  logic        out_valid;
  logic [31:0] org_data;
  logic        error;
  logic        uncorrectable;
  logic [5:0]  syndrome;

  int n_checks;
  int n_fail;

  logic [31:0] exp_d;
  logic        exp_e;
  logic        exp_u;
  logic [5:0]  exp_s;

  thc_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .data_in       (data_in),
    .out_valid     (out_valid),
    .org_data      (org_data),
    .error         (error),
    .uncorrectable (uncorrectable),
    .syndrome      (syndrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [37:0] din;
    logic [31:0] d;
    logic        e;
    logic        u;
    logic [5:0]  s;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ov, input logic [31:0] d,
                         input logic e, input logic u, input logic [5:0] s);
    chk({name, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({name, ".org_data"}, 64'(org_data), 64'(d));
    chk({name, ".error"}, 64'(error), 64'(e));
    chk({name, ".uncorrectable"}, 64'(uncorrectable), 64'(u));
    chk({name, ".syndrome"}, 64'(syndrome), 64'(s));
  endtask

  // Reference: syndrome is the XOR of the positions of all set bits.
  task automatic model(input logic [37:0] cw, output logic [31:0] d, output logic e,
                       output logic u, output logic [5:0] s);
    int syn;
    int idx;
    logic [37:0] c;
    syn = 0;
    for (int p = 1; p <= 38; p++) if (cw[p-1]) syn = syn ^ p;
    s = 6'(syn);
    e = (syn != 0);
    u = (syn > 38);
    c = cw;
    if (syn >= 1 && syn <= 38) c[syn-1] = ~c[syn-1];
    idx = 0;
    d = '0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[idx] = c[p-1];
        idx++;
      end
    end
  endtask

  task automatic encode(input logic [31:0] d, output logic [37:0] cw);
    int idx;
    int syn;
    idx = 0;
    cw = '0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[idx];
        idx++;
      end
    end
    syn = 0;
    for (int p = 1; p <= 38; p++) if (cw[p-1]) syn = syn ^ p;
    for (int k = 0; k < 6; k++) if (((syn >> k) & 1) != 0) cw[(1 << k) - 1] = 1'b1;
  endtask

  task automatic rand_word(output logic [37:0] cw);
    int mode;
    int nflip;
    encode($urandom, cw);
    mode = $urandom_range(0, 9);
    if (mode == 9) begin
      cw = {6'($urandom), 32'($urandom)};
    end else begin
      nflip = (mode < 3) ? 0 : ((mode < 7) ? 1 : 2);
      for (int f = 0; f < nflip; f++) begin
        int b;
        b = $urandom_range(0, 37);
        cw[b] = ~cw[b];
      end
    end
  endtask

  initial begin
    logic [37:0] cw;
    logic        v;
    n_checks = 0;
    n_fail   = 0;

    tbl[0] = '{"zero",       38'h0,           32'h0,         1'b0, 1'b0, 6'd0};
    tbl[1] = '{"ones",       38'h3F_7FFF_FFF4, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'd0};
    tbl[2] = '{"pos5",       38'h10,          32'h0,         1'b1, 1'b0, 6'd5};
    tbl[3] = '{"pos3",       38'h3F_7FFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'd3};
    tbl[4] = '{"pos8_par",   38'h80,          32'h0,         1'b1, 1'b0, 6'd8};
    tbl[5] = '{"uncorr39",   38'h80000040,    32'h8,         1'b1, 1'b1, 6'd39};
    tbl[6] = '{"pos38",      38'h20_0000_0000, 32'h0,        1'b1, 1'b0, 6'd38};
    tbl[7] = '{"dbl_miscor", 38'h20_8000_0000, 32'h8000_0004, 1'b1, 1'b0, 6'd6};

    // Reset held with valid input present
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 38'h3F_7FFF_FFF4;
    repeat (3) @(posedge clk);
    #1 chk_all("reset_hold", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk_all("post_reset_idle", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = tbl[i].din;
      @(posedge clk);
      #1 chk_all(tbl[i].name, 1'b1, tbl[i].d, tbl[i].e, tbl[i].u, tbl[i].s);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk_all("after_table_hold", 1'b0, tbl[7].d, tbl[7].e, tbl[7].u, tbl[7].s);

    // Five back-to-back words, then three idle cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rand_word(cw);
      in_valid = 1'b1;
      data_in  = cw;
      model(cw, exp_d, exp_e, exp_u, exp_s);
      @(posedge clk);
      #1 chk_all($sformatf("b2b%0d", i), 1'b1, exp_d, exp_e, exp_u, exp_s);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      data_in  = {6'($urandom), 32'($urandom)};
      @(posedge clk);
      #1 chk_all($sformatf("idle%0d", i), 1'b0, exp_d, exp_e, exp_u, exp_s);
    end

    // Reset asserted while a word is about to be captured
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 38'h80000040;
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(posedge clk);
    #1 chk_all("reset_discard", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk_all("reset_release", 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    exp_d = '0; exp_e = 1'b0; exp_u = 1'b0; exp_s = '0;

    // Randomized traffic with gaps against the reference model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v = ($urandom_range(0, 3) != 0);
      rand_word(cw);
      in_valid = v;
      data_in  = cw;
      if (v) model(cw, exp_d, exp_e, exp_u, exp_s);
      @(posedge clk);
      #1 chk_all($sformatf("rand%0d", i), v, exp_d, exp_e, exp_u, exp_s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
